pci_arbiter: RTL and testbench
==============================

# pci_arbiter

Central bus arbiter for the PCI model; sits directly upstream of every device's bus state machine. It samples the active-low `req_n` lines and produces the active-low `gnt_n` lines that each device registers before starting an address phase. It uses round-robin fairness, a grant-acceptance timeout, pre-emption on competing requests, and a guaranteed idle cycle between different owners.

## Interface
Parameters:
- `NUM_MASTERS`, default 3: number of req/gnt pairs, range 2..8.
- `GNT_TIMEOUT`, default 16: cycles a granted master has to assert `frame_n` before the grant is revoked, range 2..255.

Ports:
- `clk`  in  1  bus clock; all state updates on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_n`  in  NUM_MASTERS  bus requests, active low, one per master.
- `frame_n`  in  1  shared FRAME#, active low.
- `irdy_n`  in  1  shared IRDY#, active low.
- `gnt_n`  out  NUM_MASTERS  grants, active low, registered.
- `owner`  out  clog2(NUM_MASTERS)  index of current or last granted master, registered.
- `bus_idle`  out  1  high when the arbiter is in ARB_IDLE, registered.

## Operation
- Bus idle condition: `frame_n`=1 and `irdy_n`=1.
- Winner selection: round-robin starting at `last_owner`+1 and wrapping at NUM_MASTERS-1 to 0. Only masters with `req_n`=0 are eligible.
- States:
  - ARB_IDLE:
    - All `gnt_n` high.
    - If any `req_n` is low, latch the winner into `owner` and `last_owner`, drive `gnt_n[winner]` low, clear the timeout counter, and go to ARB_GRANT.
  - ARB_GRANT:
    - Hold the grant.
    - If `frame_n` is low, go to ARB_BUSY.
    - Otherwise, if `req_n[owner]` is high (request withdrawn), release the grant and go to ARB_IDLE.
    - Otherwise, if the counter equals GNT_TIMEOUT-1, release the grant and go to ARB_IDLE; the master keeps its last-served priority position.
    - Otherwise, increment the counter.
  - ARB_BUSY:
    - The transaction is in progress.
    - If any other master requests, or `req_n[owner]` goes high, deassert `gnt_n[owner]`. The owner completes its transaction without the grant (pre-emption).
    - When the bus is idle, go to ARB_TURN.
  - ARB_TURN:
    - One turnaround cycle with all `gnt_n` high.
    - Always go to ARB_IDLE.
- Invariants:
  - At most one `gnt_n` bit is low at any time.
  - A grant moves to a different master only after at least one cycle with all `gnt_n` high.
  - A grant is never reasserted in ARB_BUSY once removed.
- Simultaneous events:
  - In ARB_GRANT, `frame_n` low wins over both withdrawal and timeout in the same cycle.
  - A request from the current owner only is not pre-emption.
- Reset (any time, including mid-transaction):
  - `gnt_n` all ones, `owner`=0, `last_owner`=NUM_MASTERS-1 (master 0 wins first), counter 0, state ARB_IDLE, `bus_idle`=1.

## Timing
- Request to grant: `req_n` low sampled at edge k gives `gnt_n` low after edge k, so the device sees the grant one cycle later.
- Grant removal on withdrawal, timeout or pre-emption: registered, visible after the deciding edge.
- Timeout: the grant is asserted for exactly GNT_TIMEOUT cycles, then released.
- End of transaction to next grant: bus idle sampled at edge t gives ARB_TURN at t, ARB_IDLE at t+1, and the earliest new grant after edge t+2.
- Back-to-back grants with no transaction are separated by one ARB_IDLE cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `pci_pkg`:
  - `arb_state_t` enum (ARB_IDLE, ARB_GRANT, ARB_BUSY, ARB_TURN).
  - Constants `ARB_DEFAULT_TIMEOUT`=16 and `PCI_MAX_MASTERS`=8.
  - `bus_idle_f(frame_n, irdy_n)` helper function.
- One sub-module `pci_rr_pick`: combinational round-robin priority picker with inputs `req` (active-high vector) and `last`, and outputs `valid` and `idx`.

## Test plan
- Reset mid-grant:
  - Master 1 granted, `rst` pulses high.
  - Required: `gnt_n`=3'b111 immediately, `bus_idle`=1, and the next request from all masters grants master 0.
- Single transaction:
  - `req_n`=3'b101.
  - Required: `gnt_n`=3'b101 next cycle.
  - Then `frame_n` low for 4 cycles with `irdy_n` low.
  - Required: after both go high, one ARB_TURN cycle, then `bus_idle`=1.
- Round-robin:
  - `req_n`=3'b000 held, each winner runs a 2-cycle transaction.
  - Required: grant order 0,1,2,0,1 with an all-ones `gnt_n` cycle between owners.
- Timeout:
  - Master 2 granted, `frame_n` held high.
  - Required: `gnt_n[2]` low for exactly 16 cycles, then 3'b111, and the next grant goes to master 0 with `req_n`=3'b010.
- Pre-emption:
  - Master 0 in ARB_BUSY, master 1 asserts `req_n[1]`.
  - Required: `gnt_n[0]` high the next cycle, `gnt_n[1]` stays high until bus idle plus ARB_TURN, then goes low.
- Withdrawal vs frame:
  - Master 1 granted, `req_n[1]` goes high in the same cycle `frame_n` goes low.
  - Required: enter ARB_BUSY, no release to ARB_IDLE.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI model types: arbiter states, bus limits and the bus-idle helper.
package pci_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUSY,
        ARB_TURN
    } arb_state_t;

    localparam int unsigned ARB_DEFAULT_TIMEOUT = 16;
    localparam int unsigned PCI_MAX_MASTERS     = 8;

    function automatic logic bus_idle_f(input logic frame_n, input logic irdy_n);
        return frame_n & irdy_n;
    endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first active request after index `last`, wrapping.
module pci_rr_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic            valid,
    output logic [IdxW-1:0] idx
);

    logic [31:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last) + i) % N;
            if (!valid && req[cand[IdxW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grants with acceptance timeout, pre-emption
// during a transaction and a mandatory turnaround cycle between owners.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 3,
    parameter  int unsigned GNT_TIMEOUT = ARB_DEFAULT_TIMEOUT,
    localparam int unsigned IdxW        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_n,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    output logic [NUM_MASTERS-1:0] gnt_n,
    output logic [IdxW-1:0]        owner,
    output logic                   bus_idle
);

    localparam logic [NUM_MASTERS-1:0] One = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   bus_idle_q, bus_idle_d;

    logic                   pick_valid;
    logic [IdxW-1:0]        pick_idx;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   others_req;

    assign req        = ~req_n;
    assign owner_oh   = One << owner_q;
    assign others_req = |(req & ~owner_oh);

    pci_rr_pick #(
        .N    (NUM_MASTERS),
        .IdxW (IdxW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_n_d = gnt_n_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_n_d = '1;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    gnt_n_d = ~(One << pick_idx);
                    cnt_d   = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // FRAME# taking the bus beats both withdrawal and timeout.
                if (!frame_n) begin
                    state_d = ARB_BUSY;
                end else if (req_n[owner_q] || cnt_q == 8'(GNT_TIMEOUT - 1)) begin
                    gnt_n_d = '1;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ARB_BUSY: begin
                // Only ever cleared here, so a removed grant cannot come back mid-transaction.
                if (others_req || req_n[owner_q]) gnt_n_d = '1;
                if (bus_idle_f(frame_n, irdy_n)) begin
                    gnt_n_d = '1;
                    state_d = ARB_TURN;
                end
            end
            ARB_TURN: begin
                gnt_n_d = '1;
                state_d = ARB_IDLE;
            end
            default: begin
                gnt_n_d = '1;
                state_d = ARB_IDLE;
            end
        endcase
        bus_idle_d = (state_d == ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_n_q    <= '1;
            owner_q    <= '0;
            last_q     <= IdxW'(NUM_MASTERS - 1);
            cnt_q      <= '0;
            bus_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_n_q    <= gnt_n_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_idle_q <= bus_idle_d;
        end
    end

    assign gnt_n    = gnt_n_q;
    assign owner    = owner_q;
    assign bus_idle = bus_idle_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter with 3 masters and the default 16-cycle grant timeout.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [2:0] gnt_n;
    logic [1:0] owner;
    logic       bus_idle;

    int n_assert = 0;
    int n_fail   = 0;

    pci_arbiter #(
        .NUM_MASTERS (3),
        .GNT_TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_n    (req_n),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .gnt_n    (gnt_n),
        .owner    (owner),
        .bus_idle (bus_idle)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge; also checks the one-grant invariant.
    task automatic tick();
        @(posedge clk);
        #1;
        n_assert++;
        if ($countones(~gnt_n) > 1) begin
            n_fail++;
            $display("FAIL onehot_gnt: gnt_n=%b, required at most one low bit", gnt_n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_n = 3'b111; frame_n = 1'b1; irdy_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if (gnt_n !== 3'b111 || owner !== 2'd0 || bus_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: gnt_n=%b owner=%0d bus_idle=%b, required 111/0/1",
                     gnt_n, owner, bus_idle);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_n = 3'b101;
        tick();
        n_assert++;
        if (gnt_n !== 3'b101) begin
            n_fail++;
            $display("FAIL rmg_grant1: gnt_n=%b required 101", gnt_n);
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b1 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL rmg_async: gnt_n=%b bus_idle=%b owner=%0d, required 111/1/0",
                     gnt_n, bus_idle, owner);
        end
        #1;
        rst   = 1'b0;
        req_n = 3'b000;
        tick();
        n_assert++;
        if (gnt_n !== 3'b110 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL rmg_first: gnt_n=%b owner=%0d, required 110/0", gnt_n, owner);
        end
        req_n = 3'b111;
        tick();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_n = 3'b101;
        tick();
        n_assert++;
        if (gnt_n !== 3'b101 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: gnt_n=%b bus_idle=%b, required 101/0", gnt_n, bus_idle);
        end
        frame_n = 1'b0; irdy_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_assert++;
            if (gnt_n !== 3'b101 || bus_idle !== 1'b0) begin
                n_fail++;
                $display("FAIL single_busy%0d: gnt_n=%b bus_idle=%b, required 101/0",
                         i, gnt_n, bus_idle);
            end
        end
        frame_n = 1'b1; irdy_n = 1'b1; req_n = 3'b111;
        tick();
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_turn: gnt_n=%b bus_idle=%b, required 111/0", gnt_n, bus_idle);
        end
        tick();
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: gnt_n=%b bus_idle=%b, required 111/1", gnt_n, bus_idle);
        end
    endtask

    task automatic test_round_robin();
        int unsigned order[5] = '{0, 1, 2, 0, 1};
        logic [2:0]  e;
        do_reset();
        req_n = 3'b000;
        for (int i = 0; i < 5; i++) begin
            e = ~(3'b001 << order[i]);
            tick();
            n_assert++;
            if (gnt_n !== e || owner !== 2'(order[i])) begin
                n_fail++;
                $display("FAIL rr_grant%0d: gnt_n=%b owner=%0d, required %b/%0d",
                         i, gnt_n, owner, e, order[i]);
            end
            frame_n = 1'b0; irdy_n = 1'b0;
            tick();
            tick();
            n_assert++;
            if (gnt_n !== 3'b111) begin
                n_fail++;
                $display("FAIL rr_preempt%0d: gnt_n=%b required 111", i, gnt_n);
            end
            frame_n = 1'b1; irdy_n = 1'b1;
            tick();
            tick();
            n_assert++;
            if (gnt_n !== 3'b111 || bus_idle !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_gap%0d: gnt_n=%b bus_idle=%b, required 111/1",
                         i, gnt_n, bus_idle);
            end
        end
        req_n = 3'b111;
        tick();
    endtask

    task automatic test_timeout();
        int lowcnt = 0;
        int guard  = 0;
        do_reset();
        req_n = 3'b011;
        tick();
        while (gnt_n === 3'b011 && guard < 40) begin
            lowcnt++;
            guard++;
            tick();
        end
        n_assert++;
        if (lowcnt != 16 || gnt_n !== 3'b111) begin
            n_fail++;
            $display("FAIL timeout_len: low cycles=%0d gnt_n=%b, required 16/111", lowcnt, gnt_n);
        end
        req_n = 3'b010;
        tick();
        n_assert++;
        if (gnt_n !== 3'b110 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_next: gnt_n=%b owner=%0d, required 110/0", gnt_n, owner);
        end
        req_n = 3'b111;
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        req_n = 3'b110;
        tick();
        frame_n = 1'b0; irdy_n = 1'b0;
        tick();
        n_assert++;
        if (gnt_n !== 3'b110) begin
            n_fail++;
            $display("FAIL pre_busy: gnt_n=%b required 110", gnt_n);
        end
        req_n = 3'b100;
        tick();
        n_assert++;
        if (gnt_n !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_drop: gnt_n=%b required 111", gnt_n);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_assert++;
            if (gnt_n !== 3'b111) begin
                n_fail++;
                $display("FAIL pre_hold%0d: gnt_n=%b required 111", i, gnt_n);
            end
        end
        frame_n = 1'b1; irdy_n = 1'b1; req_n = 3'b101;
        tick();
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_turn: gnt_n=%b bus_idle=%b, required 111/0", gnt_n, bus_idle);
        end
        tick();
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_idle: gnt_n=%b bus_idle=%b, required 111/1", gnt_n, bus_idle);
        end
        tick();
        n_assert++;
        if (gnt_n !== 3'b101 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_next: gnt_n=%b owner=%0d, required 101/1", gnt_n, owner);
        end
        req_n = 3'b111;
        tick();
    endtask

    task automatic test_withdraw_vs_frame();
        do_reset();
        req_n = 3'b101;
        tick();
        req_n = 3'b111; frame_n = 1'b0;
        tick();
        n_assert++;
        if (gnt_n !== 3'b101 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL wvf_busy: gnt_n=%b bus_idle=%b, required 101/0", gnt_n, bus_idle);
        end
        tick();
        n_assert++;
        if (gnt_n !== 3'b111 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL wvf_release: gnt_n=%b bus_idle=%b, required 111/0", gnt_n, bus_idle);
        end
        frame_n = 1'b1;
        tick();
        tick();
        n_assert++;
        if (bus_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL wvf_idle: bus_idle=%b required 1", bus_idle);
        end
    endtask

    initial begin
        rst = 1'b1; req_n = 3'b111; frame_n = 1'b1; irdy_n = 1'b1;
        test_reset();
        test_reset_mid_grant();
        test_single();
        test_round_robin();
        test_timeout();
        test_preempt();
        test_withdraw_vs_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
